// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: widths, instruction field
// positions, opcode values, FSM states and the decoded control word.
package control_unit_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int PC_BITS         = 6;
    localparam int OPERATION_WIDTH = 3;
    localparam int INSTR_WIDTH     = 13 + DATA_WIDTH;

    // Instruction field positions: opc | fn | dd | aa | bb | imm
    localparam int OPC_MSB = INSTR_WIDTH - 1;
    localparam int OPC_LSB = INSTR_WIDTH - 4;
    localparam int FN_MSB  = OPC_LSB - 1;
    localparam int FN_LSB  = OPC_LSB - OPERATION_WIDTH;
    localparam int DD_MSB  = FN_LSB - 1;
    localparam int DD_LSB  = FN_LSB - 2;
    localparam int AA_MSB  = DD_LSB - 1;
    localparam int AA_LSB  = DD_LSB - 2;
    localparam int BB_MSB  = AA_LSB - 1;
    localparam int BB_LSB  = AA_LSB - 2;
    localparam int IMM_MSB = DATA_WIDTH - 1;
    localparam int IMM_LSB = 0;

    // Opcodes; 11..14 are undefined and trap as illegal
    localparam logic [3:0] OPC_NOP    = 4'd0;
    localparam logic [3:0] OPC_ALU_RR = 4'd1;
    localparam logic [3:0] OPC_ALU_RI = 4'd2;
    localparam logic [3:0] OPC_LD     = 4'd3;
    localparam logic [3:0] OPC_ST     = 4'd4;
    localparam logic [3:0] OPC_STI    = 4'd5;
    localparam logic [3:0] OPC_JMP    = 4'd6;
    localparam logic [3:0] OPC_BZ     = 4'd7;
    localparam logic [3:0] OPC_BNZ    = 4'd8;
    localparam logic [3:0] OPC_BC     = 4'd9;
    localparam logic [3:0] OPC_BN     = 4'd10;
    localparam logic [3:0] OPC_HALT   = 4'd15;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // Latched ALU flags used by conditional branches
    typedef struct packed {
        logic z;
        logic c;
        logic n;
    } flags_t;

    // Decoded control word for the instruction held in IR
    typedef struct packed {
        logic load_enable;
        logic write_ram_enable;
        logic mb_select;
        logic md_select;
        logic flag_write;
        logic branch;
        logic halt;
        logic illegal;
    } ctrl_t;

    function automatic logic [3:0] instr_opcode(input logic [INSTR_WIDTH-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit, the instruction ROM and data_unit.
interface control_unit_if;
    import control_unit_pkg::*;

    logic [PC_BITS-1:0]         instr_addr;
    logic [INSTR_WIDTH-1:0]     instr_data;
    logic                       zero_flag;
    logic                       carrier_flag;
    logic                       negative_flag;
    logic                       load_enable;
    logic                       write_ram_enable;
    logic [OPERATION_WIDTH-1:0] operation_select;
    logic [1:0]                 destination_select;
    logic [1:0]                 a_select;
    logic [1:0]                 b_select;
    logic [DATA_WIDTH-1:0]      constant_in;
    logic                       mb_select;
    logic                       md_select;
    logic                       halted;
    logic                       illegal_instr;

    // Control unit side
    modport master (
        output instr_addr,
        input  instr_data,
        input  zero_flag,
        input  carrier_flag,
        input  negative_flag,
        output load_enable,
        output write_ram_enable,
        output operation_select,
        output destination_select,
        output a_select,
        output b_select,
        output constant_in,
        output mb_select,
        output md_select,
        output halted,
        output illegal_instr
    );

    // ROM / data_unit side
    modport slave (
        input  instr_addr,
        output instr_data,
        output zero_flag,
        output carrier_flag,
        output negative_flag,
        input  load_enable,
        input  write_ram_enable,
        input  operation_select,
        input  destination_select,
        input  a_select,
        input  b_select,
        input  constant_in,
        input  mb_select,
        input  md_select,
        input  halted,
        input  illegal_instr
    );

endinterface

// File: rtl/control_unit_decoder.sv
// Combinational instruction decoder: opcode plus latched flags to the
// control word, including branch resolution and the illegal-opcode trap.
module control_unit_decoder
    import control_unit_pkg::*;
(
    input  logic [3:0] opc,
    input  flags_t     flags,
    output ctrl_t      ctrl
);

    // Opcode decode; anything not listed is an undefined opcode
    always_comb begin
        ctrl = '0;
        case (opc)
            OPC_NOP: ;
            OPC_ALU_RR: begin
                ctrl.load_enable = 1'b1;
                ctrl.flag_write  = 1'b1;
            end
            OPC_ALU_RI: begin
                ctrl.load_enable = 1'b1;
                ctrl.mb_select   = 1'b1;
                ctrl.flag_write  = 1'b1;
            end
            OPC_LD: begin
                ctrl.load_enable = 1'b1;
                ctrl.md_select   = 1'b1;
            end
            OPC_ST: begin
                ctrl.write_ram_enable = 1'b1;
            end
            OPC_STI: begin
                ctrl.write_ram_enable = 1'b1;
                ctrl.mb_select        = 1'b1;
            end
            OPC_JMP:  ctrl.branch = 1'b1;
            OPC_BZ:   ctrl.branch = flags.z;
            OPC_BNZ:  ctrl.branch = ~flags.z;
            OPC_BC:   ctrl.branch = flags.c;
            OPC_BN:   ctrl.branch = flags.n;
            OPC_HALT: ctrl.halt   = 1'b1;
            default:  ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/execute sequencer in front of data_unit. Holds PC, IR and the
// latched flag register; drives data_unit controls from IR and gates the
// two write enables so they can only be high during EXECUTE.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    localparam logic [PC_BITS-1:0] PC_ONE = 1;

    state_t                 state_reg;
    logic [PC_BITS-1:0]     pc_reg;
    logic [INSTR_WIDTH-1:0] ir_reg;
    flags_t                 flags_reg;
    flags_t                 flags_in;
    logic                   halted_reg;
    logic                   executing;
    ctrl_t                  ctrl;

    assign flags_in = '{z: bus.zero_flag, c: bus.carrier_flag, n: bus.negative_flag};

    control_unit_decoder u_decoder (
        .opc   (instr_opcode(ir_reg)),
        .flags (flags_reg),
        .ctrl  (ctrl)
    );

    // Sequencer: fetch into IR, then execute (branch, flag latch, halt)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            pc_reg     <= '0;
            ir_reg     <= '0;
            flags_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    ir_reg    <= bus.instr_data;
                    pc_reg    <= pc_reg + PC_ONE;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    // A taken branch replaces the increment done at fetch
                    if (ctrl.branch) begin
                        pc_reg <= ir_reg[IMM_LSB +: PC_BITS];
                    end
                    // Only ALU instructions update the flags a branch will test
                    if (ctrl.flag_write) begin
                        flags_reg <= flags_in;
                    end
                    if (ctrl.halt) begin
                        state_reg  <= S_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase
        end
    end

    // Enables follow the state register, so an asynchronous reset removes
    // them immediately and an in-flight write never commits
    assign executing = (state_reg == S_EXEC);

    assign bus.instr_addr         = pc_reg;
    assign bus.load_enable        = executing & ctrl.load_enable;
    assign bus.write_ram_enable   = executing & ctrl.write_ram_enable;
    assign bus.illegal_instr      = executing & ctrl.illegal;
    assign bus.halted             = halted_reg;
    assign bus.operation_select   = ir_reg[FN_MSB:FN_LSB];
    assign bus.destination_select = ir_reg[DD_MSB:DD_LSB];
    assign bus.a_select           = ir_reg[AA_MSB:AA_LSB];
    assign bus.b_select           = ir_reg[BB_MSB:BB_LSB];
    assign bus.constant_in        = ir_reg[IMM_MSB:IMM_LSB];
    assign bus.mb_select          = ctrl.mb_select;
    assign bus.md_select          = ctrl.md_select;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: ROM programs are loaded, expected PC
// steps and control events are queued, and a monitor compares them as the
// DUT presents them.
module tb_control_unit;
    import control_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    control_unit_if bus();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [INSTR_WIDTH-1:0] rom [64];
    logic [63:0]            zf_tab;
    logic [63:0]            cf_tab;
    logic [63:0]            nf_tab;
    logic [PC_BITS-1:0]     exec_addr;

    // ROM and data_unit flag model; flags are keyed by the executing address
    assign bus.instr_data    = rom[bus.instr_addr];
    assign exec_addr         = bus.instr_addr - 6'd1;
    assign bus.zero_flag     = zf_tab[exec_addr];
    assign bus.carrier_flag  = cf_tab[exec_addr];
    assign bus.negative_flag = nf_tab[exec_addr];

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [31:0] pc_q [$];
    logic [31:0] ev_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    function automatic logic [INSTR_WIDTH-1:0] enc(input logic [3:0] opc, input logic [2:0] fn,
        input logic [1:0] dd, input logic [1:0] aa, input logic [1:0] bb, input logic [7:0] imm);
        return {opc, fn, dd, aa, bb, imm};
    endfunction

    function automatic logic [21:0] ctrl_now();
        return {bus.load_enable, bus.write_ram_enable, bus.mb_select, bus.md_select,
                bus.illegal_instr, bus.operation_select, bus.destination_select,
                bus.a_select, bus.b_select, bus.constant_in};
    endfunction

    function automatic logic [31:0] ev(input logic le, input logic wre, input logic mb,
        input logic md, input logic ill, input logic [2:0] fn, input logic [1:0] dd,
        input logic [1:0] aa, input logic [1:0] bb, input logic [7:0] imm, input int c);
        logic [31:0] r;
        r = {le, wre, mb, md, ill, fn, dd, aa, bb, imm, c[9:0]};
        return r;
    endfunction

    function automatic logic [31:0] pcev(input int a, input int c);
        logic [31:0] r;
        r = {10'd0, a[5:0], c[15:0]};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%08h required=%08h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %08h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic clear_program();
        for (int i = 0; i < 64; i++) rom[i] = '0;
        zf_tab = '0;
        cf_tab = '0;
        nf_tab = '0;
        pc_q.delete();
        ev_q.delete();
    endtask

    // Monitor: every PC change and every enable/illegal cycle is a transaction
    task automatic monitor();
        logic [5:0]  prev = '0;
        logic [31:0] seen;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = '0;
            end else begin
                if (bus.instr_addr != prev) begin
                    if (mon_en) begin
                        seen = {10'd0, bus.instr_addr, cyc[15:0]};
                        if (pc_q.size() == 0) check("pc_unexpected", seen, 32'hFFFF_FFFF);
                        else                  check("pc_step", seen, pc_q.pop_front());
                    end
                    prev = bus.instr_addr;
                end
                if (mon_en && (bus.load_enable || bus.write_ram_enable || bus.illegal_instr)) begin
                    seen = {ctrl_now(), cyc[9:0]};
                    if (ev_q.size() == 0) check("ctrl_unexpected", seen, 32'hFFFF_FFFF);
                    else                  check("ctrl_event", seen, ev_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        bit found;
        fork
            monitor();
        join_none

        // ---------------- Program 1: ALU, flags, branches, stores, illegal, reset mid-ST
        clear_program();
        rom[0]  = enc(OPC_ALU_RI, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05);
        rom[1]  = enc(OPC_ALU_RR, 3'd1, 2'd2, 2'd1, 2'd2, 8'h00);
        rom[2]  = enc(OPC_LD,     3'd0, 2'd3, 2'd2, 2'd0, 8'h00);
        rom[3]  = enc(OPC_BZ,     3'd0, 2'd0, 2'd0, 2'd0, 8'd20);
        rom[20] = enc(OPC_BNZ,    3'd0, 2'd0, 2'd0, 2'd0, 8'd40);
        rom[21] = enc(OPC_STI,    3'd0, 2'd0, 2'd2, 2'd0, 8'hA5);
        rom[22] = enc(4'd12,      3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        rom[23] = enc(OPC_ST,     3'd0, 2'd0, 2'd1, 2'd3, 8'h00);
        zf_tab[1] = 1'b1;   // ALU rr produces zero; LD then sees zero_flag=0

        #12;
        check("reset_state", 32'({ctrl_now(), bus.halted, bus.instr_addr}), 32'd0);

        pc_q.push_back(pcev(1, 1));
        pc_q.push_back(pcev(2, 3));
        pc_q.push_back(pcev(3, 5));
        pc_q.push_back(pcev(4, 7));
        pc_q.push_back(pcev(20, 8));
        pc_q.push_back(pcev(21, 9));
        pc_q.push_back(pcev(22, 11));
        pc_q.push_back(pcev(23, 13));
        pc_q.push_back(pcev(24, 15));
        ev_q.push_back(ev(1, 0, 1, 0, 0, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05, 1));
        ev_q.push_back(ev(1, 0, 0, 0, 0, 3'd1, 2'd2, 2'd1, 2'd2, 8'h00, 3));
        ev_q.push_back(ev(1, 0, 0, 1, 0, 3'd0, 2'd3, 2'd2, 2'd0, 8'h00, 5));
        ev_q.push_back(ev(0, 1, 1, 0, 0, 3'd0, 2'd0, 2'd2, 2'd0, 8'hA5, 11));
        ev_q.push_back(ev(0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 13));
        ev_q.push_back(ev(0, 1, 0, 0, 0, 3'd0, 2'd0, 2'd1, 2'd3, 8'h00, 15));

        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.write_ram_enable && bus.instr_addr == 6'd24) found = 1'b1;
        end
        check("st_reached", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_st", 32'({bus.write_ram_enable, bus.load_enable, bus.halted, bus.instr_addr}), 32'd0);
        check("p1_pc_left", 32'(pc_q.size()), 32'd0);
        check("p1_ev_left", 32'(ev_q.size()), 32'd0);
        mon_en = 1'b0;

        // ---------------- Program 2: JMP 63 then NOP wraps PC to 0
        clear_program();
        rom[0] = enc(OPC_JMP, 3'd0, 2'd0, 2'd0, 2'd0, 8'd63);
        pc_q.push_back(pcev(1, 1));
        pc_q.push_back(pcev(63, 2));
        pc_q.push_back(pcev(0, 3));
        #10;
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("p2_pc_left", 32'(pc_q.size()), 32'd0);
        reset = 1'b1;

        // ---------------- Program 3: HALT at address 7
        clear_program();
        rom[7] = enc(OPC_HALT, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        for (int k = 0; k < 8; k++) pc_q.push_back(pcev(k + 1, 2 * k + 1));
        #10;
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("halt_exec_not_yet", 32'({bus.halted, bus.instr_addr}), 32'({1'b0, 6'd8}));
        @(negedge clk);
        check("halted_set", 32'({bus.halted, bus.instr_addr}), 32'({1'b1, 6'd8}));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("halt_hold",
                  32'({bus.load_enable, bus.write_ram_enable, bus.illegal_instr, bus.halted, bus.instr_addr}),
                  32'({1'b0, 1'b0, 1'b0, 1'b1, 6'd8}));
        end
        check("p3_pc_left", 32'(pc_q.size()), 32'd0);
        check("p3_ev_left", 32'(ev_q.size()), 32'd0);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_exits_halt", 32'({bus.halted, bus.instr_addr}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
